// File: rtl/sync_detect.sv
// Serial frame-sync detector: correlates the incoming bit stream against a
// sync word, verifies spacing, flywheels through misses and strobes each lock.
module sync_detect #(
    parameter logic [31:0] SYNC_WORD  = 32'h1ACFFC1D,
    parameter int          MAX_ERR    = 2,
    parameter int          FRAME_LEN  = 256,
    parameter int          VERIFY_CNT = 3,
    parameter int          MISS_MAX   = 2
) (
    input  logic        clk,
    input  logic        GlobalReset,
    input  logic        din,
    input  logic        din_valid,
    output logic [31:0] sync_o,
    output logic        srdyo,
    output logic        locked
);

    localparam logic [5:0]  MAX_ERR_W  = 6'(MAX_ERR);
    localparam logic [15:0] FRAME_W    = 16'(FRAME_LEN);
    localparam logic [3:0]  VERIFY_W   = 4'(VERIFY_CNT);
    localparam logic [3:0]  MISS_W     = 4'(MISS_MAX);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] sr;
    logic [31:0] bcnt;
    logic [5:0]  fill;
    logic [15:0] pos;
    logic [3:0]  vcnt, vcnt_nxt;
    logic [3:0]  miss, miss_nxt;
    logic        eval_q;
    logic [31:0] diff;
    logic [5:0]  err_cnt;
    logic        hit;
    logic        due;
    logic        pos_clr;
    logic        accept;
    logic [1:0]  ph;
    logic        pend;
    logic [31:0] pend_val;

    // Correlation is judged one cycle after each shift, once the register
    // holds 32 genuine bits (fill[5] set means the fill count reached 32).
    always_comb begin
        diff    = sr ^ SYNC_WORD;
        err_cnt = '0;
        for (int i = 0; i < 32; i++) begin
            err_cnt = err_cnt + 6'(diff[i]);
        end
        hit = eval_q && fill[5] && (err_cnt <= MAX_ERR_W);
        due = (pos == FRAME_W);
    end

    always_comb begin
        state_nxt = state;
        vcnt_nxt  = vcnt;
        miss_nxt  = miss;
        pos_clr   = 1'b0;
        accept    = 1'b0;
        if (eval_q) begin
            case (state)
                SEARCH: begin
                    if (hit) begin
                        pos_clr  = 1'b1;
                        vcnt_nxt = 4'd1;
                        if (VERIFY_W == 4'd1) begin
                            state_nxt = LOCKED;
                            accept    = 1'b1;
                            miss_nxt  = 4'd0;
                        end else begin
                            state_nxt = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    if (due) begin
                        if (hit) begin
                            pos_clr  = 1'b1;
                            vcnt_nxt = vcnt + 4'd1;
                            if (vcnt + 4'd1 == VERIFY_W) begin
                                state_nxt = LOCKED;
                                accept    = 1'b1;
                                miss_nxt  = 4'd0;
                            end
                        end else begin
                            state_nxt = SEARCH;
                            vcnt_nxt  = 4'd0;
                        end
                    end
                end
                LOCKED: begin
                    if (due) begin
                        pos_clr = 1'b1;
                        if (hit) begin
                            accept   = 1'b1;
                            miss_nxt = 4'd0;
                        end else if (miss + 4'd1 == MISS_W) begin
                            state_nxt = SEARCH;
                            miss_nxt  = 4'd0;
                            vcnt_nxt  = 4'd0;
                        end else begin
                            miss_nxt = miss + 4'd1;
                        end
                    end
                end
                default: begin
                    state_nxt = SEARCH;
                    vcnt_nxt  = 4'd0;
                    miss_nxt  = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state <= SEARCH;
            vcnt  <= 4'd0;
            miss  <= 4'd0;
        end else begin
            state <= state_nxt;
            vcnt  <= vcnt_nxt;
            miss  <= miss_nxt;
        end
    end

    // pos counts valid bits since the last accepted sync's final bit, so a
    // bit arriving on the same cycle as the clear already counts as 1.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            sr     <= '0;
            bcnt   <= '0;
            fill   <= '0;
            pos    <= '0;
            eval_q <= 1'b0;
        end else begin
            eval_q <= din_valid;
            if (din_valid) begin
                sr   <= {sr[30:0], din};
                bcnt <= bcnt + 32'd1;
                if (!fill[5]) begin
                    fill <= fill + 6'd1;
                end
            end
            if (pos_clr) begin
                pos <= din_valid ? 16'd1 : 16'd0;
            end else if (din_valid) begin
                pos <= pos + 16'd1;
            end
        end
    end

    // Strobe sequencer: ph 1 = value loaded, ph 2..3 = srdyo high, ph 0 =
    // idle with srdyo low; a new load is only taken from ph 0.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            sync_o   <= '0;
            ph       <= 2'd0;
            pend     <= 1'b0;
            pend_val <= '0;
        end else if (ph == 2'd0) begin
            if (accept) begin
                sync_o <= bcnt;
                ph     <= 2'd1;
                pend   <= 1'b0;
            end else if (pend) begin
                sync_o <= pend_val;
                ph     <= 2'd1;
                pend   <= 1'b0;
            end
        end else begin
            ph <= ph + 2'd1;
            if (accept) begin
                pend     <= 1'b1;
                pend_val <= bcnt;
            end
        end
    end

    assign srdyo  = ph[1];
    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_sync_detect.sv
// Directed bench for sync_detect: table-driven checks on continuous streams,
// plus hand sequences for reset, fill guard and half-rate valid.
module tb_sync_detect;

    localparam logic [31:0] SYNC = 32'h1ACFFC1D;

    logic        clk = 1'b0;
    logic        GlobalReset = 1'b1;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic [31:0] sync0, sync1;
    logic        srdy0, srdy1;
    logic        locked0, locked1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          scen;
        int          p;
        int          inst;
        logic        exp_locked;
        logic [31:0] exp_sync;
        logic        exp_srdyo;
    } vec_t;

    vec_t vecs[$];

    int          cyc = 0;
    logic        mon_en = 1'b0;
    logic        prev_srdy = 1'b0;
    int          width = 0;
    logic [31:0] caps[$];
    int          rises[$];
    int          widths[$];

    sync_detect u0 (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .din         (din),
        .din_valid   (din_valid),
        .sync_o      (sync0),
        .srdyo       (srdy0),
        .locked      (locked0)
    );

    sync_detect #(.VERIFY_CNT(1)) u1 (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .din         (din),
        .din_valid   (din_valid),
        .sync_o      (sync1),
        .srdyo       (srdy1),
        .locked      (locked1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records every srdyo pulse of u0: value at the rise, cycle, and width.
    always @(negedge clk) begin
        if (mon_en) begin
            if (srdy0 && !prev_srdy) begin
                caps.push_back(sync0);
                rises.push_back(cyc);
            end
            if (srdy0) begin
                width = width + 1;
            end else if (prev_srdy) begin
                widths.push_back(width);
                width = 0;
            end
            prev_srdy = srdy0;
        end
    end

    // Scenario 0: words every 256 bits, word 4 has 2 flips, word 5 has 3
    // flips, words 7 and 8 removed. Scenario 1: words every 255 bits.
    function automatic logic stream_bit(input int scen, input int idx);
        int          k;
        int          off;
        logic [31:0] w;
        if (scen == 0) begin
            k   = idx / 256;
            off = idx % 256;
            if (off > 31 || k > 11 || k == 7 || k == 8) return 1'b0;
            w = SYNC;
            if (k == 4) w = w ^ 32'h0000_0011;
            if (k == 5) w = w ^ 32'h0001_0101;
        end else begin
            k   = idx / 255;
            off = idx % 255;
            if (off > 31 || k > 3) return 1'b0;
            w = SYNC;
        end
        return w[31 - off];
    endfunction

    function automatic void add_vec(input int scen, input int p, input int inst,
                                    input logic l, input logic [31:0] s, input logic r);
        vec_t v;
        v.scen       = scen;
        v.p          = p;
        v.inst       = inst;
        v.exp_locked = l;
        v.exp_sync   = s;
        v.exp_srdyo  = r;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    task automatic applyStimulus(input logic b, input logic v);
        din       = b;
        din_valid = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        GlobalReset = 1'b1;
        din_valid   = 1'b0;
        din         = 1'b0;
        @(posedge clk);
        @(negedge clk);
        GlobalReset = 1'b0;
    endtask

    task automatic check_inst(input string tag, input int inst, input logic l,
                              input logic [31:0] s, input logic r);
        if (inst == 0) begin
            checkOutput({tag, "_locked"}, {31'd0, locked0}, {31'd0, l});
            checkOutput({tag, "_sync_o"}, sync0, s);
            checkOutput({tag, "_srdyo"},  {31'd0, srdy0},   {31'd0, r});
        end else begin
            checkOutput({tag, "_u1_locked"}, {31'd0, locked1}, {31'd0, l});
            checkOutput({tag, "_u1_sync_o"}, sync1, s);
            checkOutput({tag, "_u1_srdyo"},  {31'd0, srdy1},   {31'd0, r});
        end
    endtask

    task automatic run_table(input int scen, input int nbits);
        for (int p = 1; p <= nbits; p++) begin
            applyStimulus(stream_bit(scen, p - 1), 1'b1);
            foreach (vecs[j]) begin
                if (vecs[j].scen == scen && vecs[j].p == p) begin
                    check_inst($sformatf("s%0d_p%0d", scen, p), vecs[j].inst,
                               vecs[j].exp_locked, vecs[j].exp_sync, vecs[j].exp_srdyo);
                end
            end
        end
    endtask

    initial begin
        logic [31:0] exp_hr[4];
        int          start_cyc;
        logic [31:0] w;

        // p = valid bits consumed; a word ending with bcnt=L loads at p=L+1,
        // srdyo is high at p=L+2 and L+3.
        add_vec(0,   32, 1, 1'b0,  32'd0, 1'b0);
        add_vec(0,   33, 1, 1'b1,  32'd32, 1'b0);
        add_vec(0,   34, 1, 1'b1,  32'd32, 1'b1);
        add_vec(0,  544, 0, 1'b0,  32'd0, 1'b0);
        add_vec(0,  545, 0, 1'b1,  32'd544, 1'b0);
        add_vec(0,  546, 0, 1'b1,  32'd544, 1'b1);
        add_vec(0,  547, 0, 1'b1,  32'd544, 1'b1);
        add_vec(0,  548, 0, 1'b1,  32'd544, 1'b0);
        add_vec(0,  801, 0, 1'b1,  32'd800, 1'b0);
        add_vec(0,  802, 0, 1'b1,  32'd800, 1'b1);
        add_vec(0, 1057, 0, 1'b1, 32'd1056, 1'b0);
        add_vec(0, 1058, 0, 1'b1, 32'd1056, 1'b1);
        add_vec(0, 1313, 0, 1'b1, 32'd1056, 1'b0);
        add_vec(0, 1314, 0, 1'b1, 32'd1056, 1'b0);
        add_vec(0, 1315, 0, 1'b1, 32'd1056, 1'b0);
        add_vec(0, 1569, 0, 1'b1, 32'd1568, 1'b0);
        add_vec(0, 1570, 0, 1'b1, 32'd1568, 1'b1);
        add_vec(0, 1825, 0, 1'b1, 32'd1568, 1'b0);
        add_vec(0, 2080, 0, 1'b1, 32'd1568, 1'b0);
        add_vec(0, 2081, 0, 1'b0, 32'd1568, 1'b0);
        add_vec(0, 2337, 0, 1'b0, 32'd1568, 1'b0);
        add_vec(0, 2593, 0, 1'b0, 32'd1568, 1'b0);
        add_vec(0, 2848, 0, 1'b0, 32'd1568, 1'b0);
        add_vec(0, 2849, 0, 1'b1, 32'd2848, 1'b0);
        add_vec(0, 2850, 0, 1'b1, 32'd2848, 1'b1);
        add_vec(1,  289, 0, 1'b0,  32'd0, 1'b0);
        add_vec(1,  543, 0, 1'b0,  32'd0, 1'b0);
        add_vec(1,  800, 0, 1'b0,  32'd0, 1'b0);
        add_vec(1, 1050, 0, 1'b0,  32'd0, 1'b0);

        do_reset();
        check_inst("reset", 0, 1'b0, 32'd0, 1'b0);
        check_inst("reset", 1, 1'b0, 32'd0, 1'b0);

        run_table(0, 2850);

        // Reset lands while srdyo is high.
        do_reset();
        check_inst("midstrobe_reset", 0, 1'b0, 32'd0, 1'b0);

        // Low 29 bits of SYNC (its top three bits are zero) would match a
        // zeroed register before 32 bits have arrived; it must not count.
        w = SYNC;
        for (int i = 28; i >= 0; i--) applyStimulus(w[i], 1'b1);
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1);
        check_inst("fill_guard", 1, 1'b0, 32'd0, 1'b0);
        for (int i = 31; i >= 0; i--) applyStimulus(w[i], 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        check_inst("after_fill", 1, 1'b1, 32'd101, 1'b1);

        do_reset();
        run_table(1, 1050);

        // Same stream as scenario 0 with a dead cycle (random din) after
        // every valid bit.
        mon_en = 1'b1;
        do_reset();
        start_cyc = cyc;
        for (int i = 0; i < 1580; i++) begin
            applyStimulus(stream_bit(0, i), 1'b1);
            applyStimulus(1'($urandom_range(0, 1)), 1'b0);
        end
        mon_en = 1'b0;
        exp_hr[0] = 32'd544;
        exp_hr[1] = 32'd800;
        exp_hr[2] = 32'd1056;
        exp_hr[3] = 32'd1568;
        checkOutput("hr_strobe_count", caps.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < caps.size()) begin
                checkOutput($sformatf("hr_sync_o_%0d", i), caps[i], exp_hr[i]);
                checkOutput($sformatf("hr_rise_cycle_%0d", i), rises[i] - start_cyc,
                            2 * exp_hr[i] + 32'd1);
            end
            if (i < widths.size()) begin
                checkOutput($sformatf("hr_width_%0d", i), widths[i], 32'd2);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_detect.md
SYNC_DETECT -- requirements
Module: sync_detect

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 32'h1ACFFC1D, the 32-bit sync pattern (MSB received first).
REQ-002 SHALL have parameter MAX_ERR, default 2, the maximum bit mismatches accepted as a pattern hit (0..7).
REQ-003 SHALL have parameter FRAME_LEN, default 256, the valid-bit spacing between consecutive sync words (64..65535).
REQ-004 SHALL have parameter VERIFY_CNT, default 3, the consecutive spaced hits required to lock (1..15).
REQ-005 SHALL have parameter MISS_MAX, default 2, the consecutive missed syncs that drop lock (1..15).
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port GlobalReset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port din, input, 1, serial data bit.
REQ-009 SHALL have port din_valid, input, 1, qualifies din; bits are consumed only when high.
REQ-010 SHALL have port sync_o, output, 32, bit-count timestamp of the last accepted sync; drives delay_sync sync_i.
REQ-011 SHALL have port srdyo, output, 1, ready strobe; drives delay_sync srdyi, which samples on its rising edge.
REQ-012 SHALL have port locked, output, 1, high while in LOCKED state.

Function
REQ-013 SHALL shift din into a 32-bit register sr at LSB on each din_valid cycle; no shift otherwise.
REQ-014 SHALL keep a 32-bit bit counter bcnt, +1 per valid bit, wrapping 0xFFFFFFFF->0.
REQ-015 SHALL define hit = (popcount(sr XOR SYNC_WORD) <= MAX_ERR), evaluated on the cycle after each shift, and only once at least 32 valid bits have been received since reset.
REQ-016 SHALL keep a 16-bit position counter pos, reset to 0 on each accepted hit and incremented per valid bit; a "due" point occurs when pos reaches FRAME_LEN.
REQ-017 SHALL implement states SEARCH, VERIFY, LOCKED.
REQ-018 SEARCH: any hit -> VERIFY, vcnt=1, pos=0.
REQ-019 VERIFY: hit at due -> vcnt+1, pos=0; when vcnt reaches VERIFY_CNT -> LOCKED; no hit at due -> SEARCH; hits before due are ignored.
REQ-020 LOCKED: hit at due -> accepted, miss counter=0; no hit at due -> miss+1, pos=0 (flywheel); miss reaching MISS_MAX -> SEARCH, locked low next cycle.
REQ-021 SHALL treat VERIFY_CNT=1 as SEARCH hit -> LOCKED directly.
REQ-022 On every accepted hit in LOCKED (including the entering hit), SHALL load sync_o with bcnt at the hit's last bit; flywheel misses do not update sync_o or strobe.
REQ-023 SHALL raise srdyo exactly one cycle after sync_o is loaded and hold it high for 2 cycles, then low; sync_o SHALL remain stable from load until the next load.
REQ-024 A new accepted hit while srdyo is high SHALL be deferred: sync_o and strobe issue after srdyo has been low for at least 1 cycle, keeping only the newest pending value.
REQ-025 din_valid low SHALL freeze sr, bcnt, pos, and all state; pending strobe timing SHALL still proceed.

Reset
REQ-026 When GlobalReset is high at a clock edge: state=SEARCH, sr=0, bcnt=0, pos=0, vcnt=0, miss=0, sync_o=0, srdyo=0, locked=0, pending cleared.
REQ-027 Reset SHALL override all other activity, including mid-strobe (srdyo falls the next cycle) and mid-lock.
REQ-028 The 32-bit fill count SHALL restart after reset, so no hit is possible in the first 32 valid bits.

Verification
REQ-029 Exact SYNC_WORD every 256 valid bits from reset: locked rises after the third word; sync_o=bcnt at each subsequent word's last bit; srdyo is a 2-cycle pulse one cycle after the load.
REQ-030 Word with 2 flipped bits at due -> accepted; with 3 flipped bits -> miss counted, no strobe, locked stays high.
REQ-031 Locked, two consecutive syncs removed -> locked falls after the second due point; a later clean word -> VERIFY.
REQ-032 VERIFY with second word arriving at pos=255 instead of 256 -> return to SEARCH, no lock.
REQ-033 GlobalReset asserted during srdyo high -> srdyo=0, sync_o=0, locked=0 on the next cycle.
REQ-034 din_valid toggling 50% with the same bit stream -> identical sync_o values to the continuous case, with strobes at the stretched times.
